// File: rtl/tick_scheduler_pkg.sv
// tick_scheduler_pkg: shared types and default widths for the tick scheduler.
package tick_scheduler_pkg;
    localparam int DEF_TICK_W    = 8;
    localparam int DEF_TIMEOUT_W = 16;
    localparam logic [DEF_TICK_W-1:0] TICK_IDLE = '1;
    typedef enum logic [2:0] {
        S_IDLE,
        S_SPK_START,
        S_SPK_WAIT,
        S_ODIN_START,
        S_ODIN_WAIT,
        S_DONE
    } sched_state_e;
endpackage

// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if: config, core handshake and status signals of the tick scheduler.
//   slave  : the scheduler (takes start/abort/config/dones, drives starts/tick/status)
//   master : the CPU-side config plus the two cores
interface tick_scheduler_if #(
    parameter int TICK_W    = tick_scheduler_pkg::DEF_TICK_W,
    parameter int TIMEOUT_W = tick_scheduler_pkg::DEF_TIMEOUT_W
);
    logic                 start_i;
    logic                 abort_i;
    logic [TICK_W-1:0]    num_ticks_i;
    logic [TIMEOUT_W-1:0] timeout_i;
    logic                 spikecore_start_o;
    logic                 spikecore_done_i;
    logic                 odin_start_o;
    logic                 odin_done_i;
    logic [TICK_W-1:0]    tick_o;
    logic                 next_tick_o;
    logic                 busy_o;
    logic                 inference_done_o;
    logic                 error_o;
    modport slave (
        input  start_i, abort_i, num_ticks_i, timeout_i, spikecore_done_i, odin_done_i,
        output spikecore_start_o, odin_start_o, tick_o, next_tick_o, busy_o,
               inference_done_o, error_o
    );
    modport master (
        output start_i, abort_i, num_ticks_i, timeout_i, spikecore_done_i, odin_done_i,
        input  spikecore_start_o, odin_start_o, tick_o, next_tick_o, busy_o,
               inference_done_o, error_o
    );
endinterface

// File: rtl/tick_scheduler_watchdog.sv
// tick_scheduler_watchdog: per-phase cycle counter that flags when a WAIT phase runs too long.
//   clear_i   : zero the counter (asserted the cycle before a WAIT phase)
//   en_i      : high during WAIT cycles; counter advances and expiry is evaluated
//   limit_i   : WAIT cycles allowed; 0 disables expiry
//   expired_o : this WAIT cycle is the last one allowed
module tick_scheduler_watchdog
    import tick_scheduler_pkg::*;
#(
    parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic [TIMEOUT_W-1:0] limit_i,
    output logic                 expired_o
);
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    assign cnt_d = clear_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    // cnt_q counts WAIT cycles already elapsed, so the limit-th cycle is the final one
    assign expired_o = en_i && (limit_i != '0) && (cnt_q == limit_i - 1'b1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: counts an inference down tick by tick, starting spike core then ODIN core.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : start/abort/num_ticks/timeout config, core start/done handshakes,
//              tick index, next_tick pulse, busy, inference_done pulse, sticky error
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int TICK_W    = DEF_TICK_W,
    parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
    input  logic          clk,
    input  logic          rst,
    tick_scheduler_if.slave bus
);
    sched_state_e         state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [TIMEOUT_W-1:0] limit_q, limit_d;
    logic                 error_q, error_d;
    logic                 next_tick_q, next_tick_d;
    logic                 wd_expired;
    tick_scheduler_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_wd (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q == S_SPK_START || state_q == S_ODIN_START),
        .en_i     (state_q == S_SPK_WAIT || state_q == S_ODIN_WAIT),
        .limit_i  (limit_q),
        .expired_o(wd_expired)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tick_q      <= '1;
            limit_q     <= '0;
            error_q     <= 1'b0;
            next_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            limit_q     <= limit_d;
            error_q     <= error_d;
            next_tick_q <= next_tick_d;
        end
    end
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        limit_d     = limit_q;
        error_d     = error_q;
        next_tick_d = 1'b0;
        // abort outranks any done or watchdog event arriving in the same cycle
        if (bus.abort_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            tick_d  = '1;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start_i) begin
                    limit_d = bus.timeout_i;
                    error_d = 1'b0;
                    state_d = (bus.num_ticks_i == '0) ? S_DONE : S_SPK_START;
                    tick_d  = (bus.num_ticks_i == '0) ? tick_q : bus.num_ticks_i - 1'b1;
                end
                S_SPK_START:  state_d = S_SPK_WAIT;
                S_SPK_WAIT: if (bus.spikecore_done_i) state_d = S_ODIN_START;
                    else if (wd_expired) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end
                S_ODIN_START: state_d = S_ODIN_WAIT;
                S_ODIN_WAIT: if (bus.odin_done_i) begin
                        state_d     = (tick_q == '0) ? S_DONE : S_SPK_START;
                        tick_d      = (tick_q == '0) ? tick_q : tick_q - 1'b1;
                        next_tick_d = (tick_q != '0);
                    end else if (wd_expired) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end
                S_DONE: begin
                    tick_d  = '1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end
    always_comb begin
        bus.spikecore_start_o = (state_q == S_SPK_START);
        bus.odin_start_o      = (state_q == S_ODIN_START);
        bus.busy_o            = (state_q != S_IDLE);
        bus.inference_done_o  = (state_q == S_DONE);
        bus.tick_o            = tick_q;
        bus.next_tick_o       = next_tick_q;
        bus.error_o           = error_q;
    end
endmodule
